fft_64: RTL and testbench
=========================

# fft_64

Streaming-in, streaming-out 64-point radix-2 decimation-in-time FFT core for the OneSeg receiver datapath. It accepts 64 complex 11-bit samples under a valid strobe and computes the transform in place with one butterfly per clock. It then emits the 64 complex bins in natural order with a valid strobe. It sits between the sample front end and the demapper.

## Interface
- No parameters. N = 64, input width 11, internal and output width 18, and twiddle width 10 are fixed.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- valid_a  in  1  input sample strobe; the sample is taken on a rising edge where valid_a=1 and ready=1.
- ar  in  11  input real part, two's complement.
- ai  in  11  input imaginary part, two's complement.
- ready  out  1  1 while in LOAD.
- valid_x  out  1  output bin strobe.
- xk  out  6  bin index of the current output, 0..63.
- xr  out  18  output real part, two's complement.
- xi  out  18  output imaginary part, two's complement.

## Operation
- Storage is a register array mem[0..63] of complex 18-bit words.
  - Read is combinational; write happens on the clock edge.
- State LOAD (reset state):
  - On each accepted sample n (0..63), sign-extend ar/ai to 18 bits and write the value to mem[bitrev6(n)].
  - valid_a low cycles are gaps; the sample counter holds through them.
  - After sample 63, go to CALC.
- State CALC: 6 stages s=0..5, with 32 butterflies j=0..31 per stage, one butterfly per cycle.
  - Indexing: h = 2^s, top = (j>>s)*2h + (j & (h-1)), bot = top + h, twiddle index k = (j & (h-1)) << (5-s).
  - Twiddle: Wr = round(256·cos(2πk/64)), Wi = round(−256·sin(2πk/64)), 10-bit signed, held in a 32-entry ROM (round half away from zero).
  - Product: pr = br·Wr − bi·Wi and pi = br·Wi + bi·Wr, computed at full precision. Then tr = (pr+128)>>>8 and ti = (pi+128)>>>8 (arithmetic shift).
  - Update: mem[top] ← a + t and mem[bot] ← a − t, with 18-bit two's-complement wrap.
  - 18 bits is sufficient for every legal 11-bit input; no saturation logic.
  - After stage 5, j=31, go to OUT.
- State OUT:
  - For m = 0..63, present xr/xi = mem[m] with xk = m and valid_x = 1, one bin per cycle.
  - After m=63, return to LOAD with the counter at 0.
- valid_a is ignored (ready=0) in CALC and OUT; samples offered then are dropped.
- Outside OUT, valid_x=0 and xr/xi/xk hold their last value.

## Timing
- Reset values:
  - State LOAD; all counters 0; ready=1.
  - valid_x=0, xk=0, xr=0, xi=0.
  - mem contents are don't-care.
- Let E be the edge that accepts sample 63.
  - CALC occupies the 192 cycles after E.
  - Outputs are registered: valid_x first reads 1 (xk=0) 193 cycles after E, then holds 1 for 64 consecutive cycles.
- With gapless input, first-sample-to-first-bin latency is 256 cycles.
- ready falls the cycle after E and rises the cycle after the last bin (xk=63).
  - A new frame may start that cycle.
- RST asserted in any state:
  - Aborts immediately to LOAD with the reset values.
  - A partial frame is discarded; no output is produced for it.

## Test plan
- Impulse: ar=1 at n=0, all other samples 0 -> 64 bins xr=1, xi=0, xk=0..63 in order, valid_x high 64 cycles.
- DC: ar=100, ai=50 for all n -> bin 0 is xr=6400, xi=3200; all other bins are 0.
- Nyquist: ar alternating +100/−100 starting +100, ai=0 -> bin 32 is xr=6400; all others 0.
- Full-scale worst case: ar=−1024, ai=−1024 constant -> bin 0 is xr=xi=−65536 with no wrap; other bins 0.
- Mixed random frame of 64 signed samples in [−15,15], with gaps inserted on valid_a -> bins match a bit-exact model of the Operation rules; valid_x starts 193 cycles after the 64th accepted sample.
- Reset abort: assert RST during CALC -> ready=1 and valid_x=0 immediately. A fresh impulse frame afterward yields all-ones output.

Source files
------------

// File: rtl/fft_64.sv
// 64-point radix-2 DIT FFT: bit-reversed load, in-place butterflies (one per clock)
// over a register-array memory, then natural-order readout of all 64 bins.
module fft_64 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid_a,
  input  logic [10:0] ar,
  input  logic [10:0] ai,
  output logic        ready,
  output logic        valid_x,
  output logic [5:0]  xk,
  output logic [17:0] xr,
  output logic [17:0] xi
);

  typedef enum logic [1:0] {LOAD, CALC, OUTP} state_e;

  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] stg_q, stg_d;
  logic [4:0] bf_q, bf_d;
  logic        vx_q, vx_d;
  logic [5:0]  xk_q, xk_d;
  logic [17:0] xr_q, xr_d, xi_q, xi_d;

  logic signed [17:0] mem_re_q [64];
  logic signed [17:0] mem_im_q [64];

  logic [5:0]  hbit, hmask, top, bot;
  logic [4:0]  tw_k;
  logic signed [9:0]  wr, wi;
  logic signed [17:0] a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [25:0] pr, pi;

  function automatic logic [5:0] bitrev6(input logic [5:0] v);
    return {v[0], v[1], v[2], v[3], v[4], v[5]};
  endfunction

  // round(256*cos(i*2pi/64)) for the first quadrant, i = 0..16
  function automatic logic signed [9:0] cos_q(input logic [4:0] i);
    case (i)
      5'd0:  return 10'sd256;
      5'd1:  return 10'sd255;
      5'd2:  return 10'sd251;
      5'd3:  return 10'sd245;
      5'd4:  return 10'sd237;
      5'd5:  return 10'sd226;
      5'd6:  return 10'sd213;
      5'd7:  return 10'sd198;
      5'd8:  return 10'sd181;
      5'd9:  return 10'sd162;
      5'd10: return 10'sd142;
      5'd11: return 10'sd121;
      5'd12: return 10'sd98;
      5'd13: return 10'sd74;
      5'd14: return 10'sd50;
      5'd15: return 10'sd25;
      default: return 10'sd0;
    endcase
  endfunction

  // Butterfly addressing and twiddle for the current (stage, j)
  always_comb begin
    hbit  = 6'd1 << stg_q;
    hmask = hbit - 6'd1;
    top   = (({1'b0, bf_q} >> stg_q) << (stg_q + 3'd1)) | ({1'b0, bf_q} & hmask);
    bot   = top | hbit;
    tw_k  = (bf_q & hmask[4:0]) << (3'd5 - stg_q);
    if (tw_k <= 5'd16) begin
      wr = cos_q(tw_k);
      wi = -cos_q(5'd16 - tw_k);
    end else begin
      wr = -cos_q(5'd0 - tw_k);
      wi = -cos_q(tw_k - 5'd16);
    end
  end

  // Only bits [25:8] of the rounded product survive, so 26-bit modular math is exact
  always_comb begin
    a_re = mem_re_q[top];
    a_im = mem_im_q[top];
    b_re = mem_re_q[bot];
    b_im = mem_im_q[bot];
    pr   = 26'(b_re) * 26'(wr) - 26'(b_im) * 26'(wi);
    pi   = 26'(b_re) * 26'(wi) + 26'(b_im) * 26'(wr);
    t_re = 18'((pr + 26'sd128) >>> 8);
    t_im = 18'((pi + 26'sd128) >>> 8);
  end

  always_ff @(posedge CLK) begin
    if (state_q == LOAD && valid_a) begin
      mem_re_q[bitrev6(cnt_q)] <= 18'($signed(ar));
      mem_im_q[bitrev6(cnt_q)] <= 18'($signed(ai));
    end else if (state_q == CALC) begin
      mem_re_q[top] <= a_re + t_re;
      mem_im_q[top] <= a_im + t_im;
      mem_re_q[bot] <= a_re - t_re;
      mem_im_q[bot] <= a_im - t_im;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (valid_a && cnt_q == 6'd63) state_d = CALC;
      CALC:    if (stg_q == 3'd5 && bf_q == 5'd31) state_d = OUTP;
      OUTP:    if (cnt_q == 6'd63) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    ready = (state_q == LOAD);
  end

  // cnt is shared: sample index in LOAD, bin index in OUT; it wraps to 0 on each exit
  always_comb begin
    cnt_d = cnt_q;
    stg_d = stg_q;
    bf_d  = bf_q;
    vx_d  = 1'b0;
    xk_d  = xk_q;
    xr_d  = xr_q;
    xi_d  = xi_q;
    case (state_q)
      LOAD: if (valid_a) cnt_d = cnt_q + 6'd1;
      CALC: begin
        bf_d = bf_q + 5'd1;
        if (bf_q == 5'd31) stg_d = (stg_q == 3'd5) ? 3'd0 : stg_q + 3'd1;
      end
      OUTP: begin
        cnt_d = cnt_q + 6'd1;
        vx_d  = 1'b1;
        xk_d  = cnt_q;
        xr_d  = mem_re_q[cnt_q];
        xi_d  = mem_im_q[cnt_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= 6'd0;
      stg_q <= 3'd0;
      bf_q  <= 5'd0;
      vx_q  <= 1'b0;
      xk_q  <= 6'd0;
      xr_q  <= 18'd0;
      xi_q  <= 18'd0;
    end else begin
      cnt_q <= cnt_d;
      stg_q <= stg_d;
      bf_q  <= bf_d;
      vx_q  <= vx_d;
      xk_q  <= xk_d;
      xr_q  <= xr_d;
      xi_q  <= xi_d;
    end
  end

  assign valid_x = vx_q;
  assign xk      = xk_q;
  assign xr      = xr_q;
  assign xi      = xi_q;

endmodule

// File: tb/tb_fft_64.sv
// Self-checking bench for fft_64: directed patterns, random gapped frames against a
// real-arithmetic reference FFT, and reset aborts.
module tb_fft_64;
  logic        CLK = 1'b0;
  logic        RST;
  logic        valid_a;
  logic [10:0] ar, ai;
  logic        ready, valid_x;
  logic [5:0]  xk;
  logic [17:0] xr, xi;

  fft_64 dut (.CLK(CLK), .RST(RST), .valid_a(valid_a), .ar(ar), .ai(ai), .ready(ready),
              .valid_x(valid_x), .xk(xk), .xr(xr), .xi(xi));

  always #5 CLK = ~CLK;

  int cmp = 0, errs = 0;
  int in_re[64], in_im[64], exp_re[64], exp_im[64];
  int cap_re[64], cap_im[64], cap_k[64], cap_v[64];
  int lat;
  const real PI = 3.14159265358979323846;

  function automatic longint wrap18(input longint x);
    longint r;
    r = x & 64'h3FFFF;
    if (r >= 131072) r = r - 262144;
    return r;
  endfunction

  function automatic longint round_afz(input real r);
    if (r >= 0.0) return longint'($floor(r + 0.5));
    else          return -longint'($floor(-r + 0.5));
  endfunction

  function automatic int bitrev6(input int n);
    int r = 0;
    for (int b = 0; b < 6; b++) if (n & (1 << b)) r |= 1 << (5 - b);
    return r;
  endfunction

  // Reference transform straight from the arithmetic rules, twiddles from real trig
  task automatic model_fft();
    longint mr[64], mi[64];
    longint h, top, bot, k, wr, wi, pr, pim, tr, ti, a_r, a_i;
    for (int n = 0; n < 64; n++) begin
      mr[bitrev6(n)] = in_re[n];
      mi[bitrev6(n)] = in_im[n];
    end
    for (int s = 0; s < 6; s++) begin
      h = 1 << s;
      for (int j = 0; j < 32; j++) begin
        top = (j / h) * 2 * h + (j % h);
        bot = top + h;
        k   = (j % h) * (32 / h);
        wr  = round_afz(256.0 * $cos(2.0 * PI * k / 64.0));
        wi  = round_afz(-256.0 * $sin(2.0 * PI * k / 64.0));
        pr  = mr[bot] * wr - mi[bot] * wi;
        pim = mr[bot] * wi + mi[bot] * wr;
        tr  = (pr + 128) >>> 8;
        ti  = (pim + 128) >>> 8;
        a_r = mr[top];
        a_i = mi[top];
        mr[top] = wrap18(a_r + tr);
        mi[top] = wrap18(a_i + ti);
        mr[bot] = wrap18(a_r - tr);
        mi[bot] = wrap18(a_i - ti);
      end
    end
    for (int i = 0; i < 64; i++) begin
      exp_re[i] = int'(mr[i]);
      exp_im[i] = int'(mi[i]);
    end
  endtask

  // Feeds in_re/in_im; returns at the negedge just after the edge taking sample 63
  task automatic send_frame(input bit gaps);
    int n = 0, guard = 0;
    bit acc;
    @(negedge CLK);
    while (n < 64 && guard < 5000) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        valid_a = 1'b0;
        ar = 11'($urandom);
        ai = 11'($urandom);
      end else begin
        valid_a = 1'b1;
        ar = 11'(in_re[n]);
        ai = 11'(in_im[n]);
      end
      acc = valid_a && ready;
      @(negedge CLK);
      if (acc) n++;
      guard++;
    end
    valid_a = 1'b0;
    ar = '0;
    ai = '0;
    cmp++;
    if (n != 64) begin
      errs++;
      $display("FAIL send_timeout: accepted %0d samples, required 64", n);
    end
  endtask

  // Counts cycles from the last accepted sample to the first bin, then grabs 64 cycles
  task automatic capture(input bit junk);
    lat = 0;
    while (valid_x !== 1'b1 && lat < 1000) begin
      if (junk) begin
        valid_a = 1'b1;
        ar = 11'($urandom);
        ai = 11'($urandom);
      end
      @(negedge CLK);
      lat++;
    end
    valid_a = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cap_re[i] = $signed(xr);
      cap_im[i] = $signed(xi);
      cap_k[i]  = xk;
      cap_v[i]  = valid_x;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    valid_a = 1'b0;
    ar = '0;
    ai = '0;
    repeat (2) @(negedge CLK);
    cmp++; if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", ready); end
    cmp++; if (valid_x !== 1'b0) begin errs++; $display("FAIL reset_valid_x: got %b want 0", valid_x); end
    cmp++; if (xk !== 6'd0) begin errs++; $display("FAIL reset_xk: got %0d want 0", xk); end
    cmp++; if (xr !== 18'd0) begin errs++; $display("FAIL reset_xr: got %0d want 0", xr); end
    cmp++; if (xi !== 18'd0) begin errs++; $display("FAIL reset_xi: got %0d want 0", xi); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_impulse();
    for (int n = 0; n < 64; n++) begin
      in_re[n] = (n == 0) ? 1 : 0;
      in_im[n] = 0;
    end
    send_frame(1'b0);
    cmp++; if (ready !== 1'b0) begin errs++; $display("FAIL impulse_ready_drop: got %b want 0", ready); end
    capture(1'b0);
    cmp++; if (lat != 193) begin errs++; $display("FAIL impulse_latency: got %0d want 193", lat); end
    for (int i = 0; i < 64; i++) begin
      cmp++;
      if (cap_v[i] != 1 || cap_k[i] != i || cap_re[i] != 1 || cap_im[i] != 0) begin
        errs++;
        $display("FAIL impulse_bin %0d: got v=%0d k=%0d (%0d,%0d) want v=1 k=%0d (1,0)",
                 i, cap_v[i], cap_k[i], cap_re[i], cap_im[i], i);
      end
    end
    cmp++;
    if (valid_x !== 1'b0 || ready !== 1'b1) begin
      errs++;
      $display("FAIL impulse_end: got valid_x=%b ready=%b want 0/1", valid_x, ready);
    end
  endtask

  // DC, Nyquist and full-scale constant frames with closed-form expected spectra
  task automatic test_patterns();
    int kb, vr, vi, er, ei;
    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < 64; n++) begin
        case (p)
          0: begin in_re[n] = 100; in_im[n] = 50; end
          1: begin in_re[n] = (n % 2 == 0) ? 100 : -100; in_im[n] = 0; end
          default: begin in_re[n] = -1024; in_im[n] = -1024; end
        endcase
      end
      case (p)
        0: begin kb = 0;  vr = 6400;   vi = 3200;   end
        1: begin kb = 32; vr = 6400;   vi = 0;      end
        default: begin kb = 0; vr = -65536; vi = -65536; end
      endcase
      send_frame(1'b0);
      capture(1'b0);
      cmp++; if (lat != 193) begin errs++; $display("FAIL pattern%0d_latency: got %0d want 193", p, lat); end
      for (int i = 0; i < 64; i++) begin
        er = (i == kb) ? vr : 0;
        ei = (i == kb) ? vi : 0;
        cmp++;
        if (cap_v[i] != 1 || cap_k[i] != i || cap_re[i] != er || cap_im[i] != ei) begin
          errs++;
          $display("FAIL pattern%0d_bin %0d: got v=%0d k=%0d (%0d,%0d) want v=1 k=%0d (%0d,%0d)",
                   p, i, cap_v[i], cap_k[i], cap_re[i], cap_im[i], i, er, ei);
        end
      end
    end
  endtask

  // Two gapped random frames back to back, junk offered while busy must be dropped
  task automatic test_random_gaps();
    for (int f = 0; f < 2; f++) begin
      for (int n = 0; n < 64; n++) begin
        in_re[n] = int'($urandom_range(30)) - 15;
        in_im[n] = int'($urandom_range(30)) - 15;
      end
      model_fft();
      send_frame(1'b1);
      cmp++; if (ready !== 1'b0) begin errs++; $display("FAIL random%0d_ready_drop: got %b want 0", f, ready); end
      capture(1'b1);
      cmp++; if (lat != 193) begin errs++; $display("FAIL random%0d_latency: got %0d want 193", f, lat); end
      for (int i = 0; i < 64; i++) begin
        cmp++;
        if (cap_v[i] != 1 || cap_k[i] != i || cap_re[i] != exp_re[i] || cap_im[i] != exp_im[i]) begin
          errs++;
          $display("FAIL random%0d_bin %0d: got v=%0d k=%0d (%0d,%0d) want v=1 k=%0d (%0d,%0d)",
                   f, i, cap_v[i], cap_k[i], cap_re[i], cap_im[i], i, exp_re[i], exp_im[i]);
        end
      end
      cmp++;
      if (valid_x !== 1'b0 || ready !== 1'b1) begin
        errs++;
        $display("FAIL random%0d_end: got valid_x=%b ready=%b want 0/1", f, valid_x, ready);
      end
    end
  endtask

  task automatic test_reset_abort();
    int seen, w;
    for (int n = 0; n < 64; n++) begin
      in_re[n] = int'($urandom_range(30)) - 15;
      in_im[n] = int'($urandom_range(30)) - 15;
    end
    send_frame(1'b0);
    repeat (40) @(negedge CLK);
    RST = 1'b1;
    #1;
    cmp++;
    if (ready !== 1'b1 || valid_x !== 1'b0) begin
      errs++;
      $display("FAIL abort_calc: got ready=%b valid_x=%b want 1/0", ready, valid_x);
    end
    @(negedge CLK);
    RST = 1'b0;
    seen = 0;
    repeat (300) begin
      @(negedge CLK);
      if (valid_x === 1'b1) seen++;
    end
    cmp++; if (seen != 0) begin errs++; $display("FAIL abort_no_output: got %0d bins want 0", seen); end

    send_frame(1'b0);
    w = 0;
    while (valid_x !== 1'b1 && w < 1000) begin @(negedge CLK); w++; end
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    #1;
    cmp++;
    if (valid_x !== 1'b0 || ready !== 1'b1 || xk !== 6'd0 || xr !== 18'd0 || xi !== 18'd0) begin
      errs++;
      $display("FAIL abort_out: got valid_x=%b ready=%b xk=%0d xr=%0d xi=%0d want 0/1/0/0/0",
               valid_x, ready, xk, xr, xi);
    end
    @(negedge CLK);
    RST = 1'b0;

    // partial frame then reset: the next frame must start at sample 0 again
    repeat (20) begin
      valid_a = 1'b1;
      ar = 11'($urandom);
      ai = 11'($urandom);
      @(negedge CLK);
    end
    valid_a = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int n = 0; n < 64; n++) begin
      in_re[n] = (n == 0) ? 1 : 0;
      in_im[n] = 0;
    end
    send_frame(1'b1);
    capture(1'b0);
    cmp++; if (lat != 193) begin errs++; $display("FAIL abort_impulse_latency: got %0d want 193", lat); end
    for (int i = 0; i < 64; i++) begin
      cmp++;
      if (cap_v[i] != 1 || cap_k[i] != i || cap_re[i] != 1 || cap_im[i] != 0) begin
        errs++;
        $display("FAIL abort_impulse_bin %0d: got v=%0d k=%0d (%0d,%0d) want v=1 k=%0d (1,0)",
                 i, cap_v[i], cap_k[i], cap_re[i], cap_im[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_patterns();
    test_random_gaps();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
